// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, redirect sources,
// default reset/exception addresses and the optional NPC window check.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FETCH_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] FETCH_WINDOW   = 32'h0000_3FFC;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_HOLD_PEND = 2'd2
  } state_e;

  // Numeric order is the redirect priority; larger wins.
  typedef enum logic [1:0] {
    SRC_SEQ  = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2,
    SRC_EXC  = 2'd3
  } src_e;

  function automatic logic npc_out_of_range(input logic [31:0] npc,
                                            input logic [31:0] base);
    return (npc < base) || (npc > base + FETCH_WINDOW) || (npc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_seq_npc_sel.sv
// npc_sel: combinational redirect priority mux (exception > eret > branch >
// sequential), returning the chosen target, its flush flag and its source.
module npc_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = FETCH_EXC_VEC
) (
  input  logic [31:0] i_pc,
  input  logic        i_br_take,
  input  logic [31:0] i_br_target,
  input  logic        i_exc_req,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  output logic [31:0] o_target,
  output logic        o_flush,
  output logic [1:0]  o_src
);

  // NOTE: every output gets a default before the priority chain so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    o_target = i_pc + 32'd4;
    o_flush  = 1'b0;
    o_src    = SRC_SEQ;
    if (i_exc_req) begin
      o_target = EXC_VEC;
      o_flush  = 1'b1;
      o_src    = SRC_EXC;
    end else if (i_eret) begin
      o_target = i_epc;
      o_flush  = 1'b1;
      o_src    = SRC_ERET;
    end else if (i_br_take) begin
      // Branch delay slot still executes, so no squash here.
      o_target = i_br_target;
      o_src    = SRC_BR;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch PC sequencer: picks the next PC, buffers redirects across stalls and
// counts PC advances. Define FETCH_SEQ_BOUND_CHECK_EN to trap out-of-window NPCs.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] EXC_VEC  = FETCH_EXC_VEC
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC_in,
  input  logic        Stall,
  input  logic        Br_Take,
  input  logic [31:0] Br_Target,
  input  logic        Exc_Req,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic [31:0] NPC,
  output logic        PC_We,
  output logic        Flush_D,
  output logic        Pend,
  output logic [31:0] Fetch_Cnt
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pend_target;
  logic [31:0] w_pend_target_nxt;
  logic        r_pend_flush;
  logic        w_pend_flush_nxt;
  src_e        r_pend_src;
  src_e        w_pend_src_nxt;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_sel_target;
  logic        w_sel_flush;
  logic [1:0]  w_sel_src_raw;
  src_e        w_sel_src;

  logic [31:0] w_npc_raw;
  logic        w_we_raw;
  logic        w_flush_raw;
  logic [31:0] w_npc_chk;
  logic        w_flush_chk;

  npc_sel #(
    .EXC_VEC (EXC_VEC)
  ) u_npc_sel (
    .i_pc        (PC_in),
    .i_br_take   (Br_Take),
    .i_br_target (Br_Target),
    .i_exc_req   (Exc_Req),
    .i_eret      (Eret),
    .i_epc       (EPC),
    .o_target    (w_sel_target),
    .o_flush     (w_sel_flush),
    .o_src       (w_sel_src_raw)
  );

  assign w_sel_src = src_e'(w_sel_src_raw);

  always_comb begin
    w_state_nxt       = r_state;
    w_pend_target_nxt = r_pend_target;
    w_pend_flush_nxt  = r_pend_flush;
    w_pend_src_nxt    = r_pend_src;
    w_npc_raw         = w_sel_target;
    w_we_raw          = 1'b0;
    w_flush_raw       = 1'b0;

    if (Exc_Req) begin
      // An accepted exception beats the stall and drops anything buffered.
      w_we_raw          = 1'b1;
      w_flush_raw       = 1'b1;
      w_state_nxt       = ST_RUN;
      w_pend_target_nxt = '0;
      w_pend_flush_nxt  = 1'b0;
      w_pend_src_nxt    = SRC_SEQ;
    end else begin
      case (r_state)
        ST_RUN, ST_HOLD: begin
          if (!Stall) begin
            w_we_raw    = 1'b1;
            w_flush_raw = w_sel_flush;
            w_state_nxt = ST_RUN;
          end else if (w_sel_src != SRC_SEQ) begin
            w_state_nxt       = ST_HOLD_PEND;
            w_pend_target_nxt = w_sel_target;
            w_pend_flush_nxt  = w_sel_flush;
            w_pend_src_nxt    = w_sel_src;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD_PEND: begin
          if (!Stall) begin
            w_we_raw          = 1'b1;
            w_npc_raw         = r_pend_target;
            w_flush_raw       = r_pend_flush;
            w_state_nxt       = ST_RUN;
            w_pend_target_nxt = '0;
            w_pend_flush_nxt  = 1'b0;
            w_pend_src_nxt    = SRC_SEQ;
          end else if (w_sel_src > r_pend_src) begin
            w_pend_target_nxt = w_sel_target;
            w_pend_flush_nxt  = w_sel_flush;
            w_pend_src_nxt    = w_sel_src;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

`ifdef FETCH_SEQ_BOUND_CHECK_EN
  always_comb begin
    w_npc_chk   = w_npc_raw;
    w_flush_chk = w_flush_raw;
    if (w_we_raw && (w_npc_raw != EXC_VEC) && npc_out_of_range(w_npc_raw, RESET_PC)) begin
      w_npc_chk   = EXC_VEC;
      w_flush_chk = 1'b1;
    end
  end
`else
  assign w_npc_chk   = w_npc_raw;
  assign w_flush_chk = w_flush_raw;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_RUN;
      r_pend_target <= '0;
      r_pend_flush  <= 1'b0;
      r_pend_src    <= SRC_SEQ;
      r_fetch_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_pend_flush  <= w_pend_flush_nxt;
      r_pend_src    <= w_pend_src_nxt;
      if (w_we_raw) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign NPC       = Rst ? RESET_PC : w_npc_chk;
  assign PC_We     = Rst | w_we_raw;
  assign Flush_D   = ~Rst & w_flush_chk;
  assign Pend      = ~Rst & (r_state == ST_HOLD_PEND);
  assign Fetch_Cnt = r_fetch_cnt;

endmodule
